// File: rtl/sm_clk_ctrl.sv
// Stepping clock generator: synchronised controls, debounced step button and an
// IDLE/HIGH/LOW FSM producing glitch-free half-periods of 2^b input cycles.
module sm_clk_ctrl #(
  parameter int SHIFT     = 16,
  parameter int SEL_W     = 4,
  parameter int BL_W      = 8,
  parameter int DB_CYCLES = 16
) (
  input  logic             clkIn,
  input  logic             rst_n,
  input  logic [SEL_W-1:0] devide,
  input  logic [1:0]       mode,
  input  logic             step,
  input  logic [BL_W-1:0]  burstLen,
  output logic             clkOut,
  output logic             tick,
  output logic             busy
);

  localparam logic [1:0] MODE_STOP  = 2'b00;
  localparam logic [1:0] MODE_RUN   = 2'b01;
  localparam logic [1:0] MODE_STEP  = 2'b10;
  localparam logic [1:0] MODE_BURST = 2'b11;

  localparam int              DB_W    = $clog2(DB_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  logic [SEL_W-1:0] devMeta;
  logic [SEL_W-1:0] syncDevide;
  logic [1:0]       modeMeta;
  logic [1:0]       syncMode;
  logic             stepMeta;
  logic             syncStep;

  always_ff @(posedge clkIn or negedge rst_n) begin
    if (!rst_n) begin
      devMeta    <= '0;
      syncDevide <= '0;
      modeMeta   <= '0;
      syncMode   <= '0;
      stepMeta   <= 1'b0;
      syncStep   <= 1'b0;
    end else begin
      devMeta    <= devide;
      syncDevide <= devMeta;
      modeMeta   <= mode;
      syncMode   <= modeMeta;
      stepMeta   <= step;
      syncStep   <= stepMeta;
    end
  end

  // Debouncer: the accepted level only moves after DB_CYCLES straight disagreements.
  logic [DB_W-1:0] dbCnt;
  logic            dbLevel;
  logic            dbLevelDly;
  logic            stepReq;

  always_ff @(posedge clkIn or negedge rst_n) begin
    if (!rst_n) begin
      dbCnt      <= '0;
      dbLevel    <= 1'b0;
      dbLevelDly <= 1'b0;
    end else begin
      dbLevelDly <= dbLevel;
      if (syncStep != dbLevel) begin
        if (dbCnt == DB_LAST) begin
          dbLevel <= ~dbLevel;
          dbCnt   <= '0;
        end else begin
          dbCnt <= dbCnt + DB_W'(1);
        end
      end else begin
        dbCnt <= '0;
      end
    end
  end

  assign stepReq = dbLevel & ~dbLevelDly;

  state_t          state;
  logic [4:0]      b;
  logic [31:0]     halfCnt;
  logic [BL_W-1:0] remain;
  logic [1:0]      actMode;

  logic [31:0]     devSum;
  logic [4:0]      bNext;
  logic [31:0]     halfLast;
  logic            halfDone;
  logic [BL_W-1:0] burstLoad;
  logic [BL_W-1:0] remainDec;
  logic            startReq;
  logic            lowContinue;

  assign devSum    = 32'(SHIFT) + 32'(syncDevide);
  assign bNext     = (devSum > 32'd31) ? 5'd31 : devSum[4:0];
  assign halfLast  = (32'd1 << b) - 32'd1;
  assign halfDone  = (halfCnt == halfLast);
  assign burstLoad = (burstLen == '0) ? BL_W'(1) : burstLen;
  assign remainDec = remain - BL_W'(1);

  always_comb begin
    startReq = 1'b0;
    case (actMode)
      MODE_RUN:              startReq = 1'b1;
      MODE_STEP, MODE_BURST: startReq = stepReq;
      default:               startReq = 1'b0;
    endcase
  end

  // End-of-period decision uses the freshly sampled mode; a drop out of RUN never
  // inherits a stale burst count.
  always_comb begin
    lowContinue = 1'b0;
    case (syncMode)
      MODE_RUN:  lowContinue = 1'b1;
      MODE_STOP: lowContinue = 1'b0;
      default:   lowContinue = (actMode != MODE_RUN) && (remainDec != '0);
    endcase
  end

  always_ff @(posedge clkIn or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      b       <= '0;
      halfCnt <= '0;
      remain  <= '0;
      actMode <= MODE_STOP;
      clkOut  <= 1'b0;
      tick    <= 1'b0;
      busy    <= 1'b0;
    end else begin
      tick <= 1'b0;
      case (state)
        IDLE: begin
          actMode <= syncMode;
          halfCnt <= '0;
          if (startReq) begin
            state  <= HIGH;
            b      <= bNext;
            clkOut <= 1'b1;
            tick   <= 1'b1;
            busy   <= 1'b1;
            case (actMode)
              MODE_STEP:  remain <= BL_W'(1);
              MODE_BURST: remain <= burstLoad;
              default:    remain <= '0;
            endcase
          end
        end

        HIGH: begin
          if (halfDone) begin
            state   <= LOW;
            halfCnt <= '0;
            clkOut  <= 1'b0;
          end else begin
            halfCnt <= halfCnt + 32'd1;
          end
        end

        LOW: begin
          if (halfDone) begin
            halfCnt <= '0;
            actMode <= syncMode;
            if ((syncMode == MODE_STEP || syncMode == MODE_BURST) && actMode != MODE_RUN) begin
              remain <= remainDec;
            end
            if (lowContinue) begin
              state  <= HIGH;
              b      <= bNext;
              clkOut <= 1'b1;
              tick   <= 1'b1;
            end else begin
              state  <= IDLE;
              remain <= '0;
              busy   <= 1'b0;
            end
          end else begin
            halfCnt <= halfCnt + 32'd1;
          end
        end

        default: begin
          state   <= IDLE;
          halfCnt <= '0;
          clkOut  <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sm_clk_ctrl.sv
// Randomised bench for sm_clk_ctrl: a period-schedule reference model predicts
// clkOut/tick/busy every cycle; directed phases pin down the tick counts.
module tb_sm_clk_ctrl;

  localparam int SHIFT     = 1;
  localparam int SEL_W     = 2;
  localparam int BL_W      = 4;
  localparam int DB_CYCLES = 4;

  localparam logic [1:0] M_STOP  = 2'b00;
  localparam logic [1:0] M_RUN   = 2'b01;
  localparam logic [1:0] M_STEP  = 2'b10;
  localparam logic [1:0] M_BURST = 2'b11;

  logic             clkIn;
  logic             rst_n;
  logic [SEL_W-1:0] devide;
  logic [1:0]       mode;
  logic             step;
  logic [BL_W-1:0]  burstLen;
  logic             clkOut;
  logic             tick;
  logic             busy;

  sm_clk_ctrl #(
    .SHIFT    (SHIFT),
    .SEL_W    (SEL_W),
    .BL_W     (BL_W),
    .DB_CYCLES(DB_CYCLES)
  ) dut (
    .clkIn   (clkIn),
    .rst_n   (rst_n),
    .devide  (devide),
    .mode    (mode),
    .step    (step),
    .burstLen(burstLen),
    .clkOut  (clkOut),
    .tick    (tick),
    .busy    (busy)
  );

  initial clkIn = 1'b0;
  always #5 clkIn = ~clkIn;

  int checks = 0;
  int errors = 0;
  int dutTicks = 0;
  int modelTicks = 0;
  int phaseNo = 0;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: input delay lines, accepted button level, and the
  // currently running period described by its start cycle and half length.
  logic [1:0]       mMode1, mMode2;
  logic [SEL_W-1:0] mDev1, mDev2;
  logic             mStep1, mStep2;
  logic             mLevel, mRise, mTick, mActive;
  int               mRun, mLeft;
  int unsigned      mCyc, mStart, mHalf;
  logic [1:0]       mAct;

  task automatic modelReset();
    mMode1 = '0; mMode2 = '0; mDev1 = '0; mDev2 = '0;
    mStep1 = 1'b0; mStep2 = 1'b0;
    mLevel = 1'b0; mRise = 1'b0; mTick = 1'b0; mActive = 1'b0;
    mRun = 0; mLeft = 0; mStart = 0; mHalf = 1;
    mAct = M_STOP;
  endtask

  task automatic startPeriod(input logic [SEL_W-1:0] dev);
    int e;
    e = SHIFT + int'(dev);
    if (e > 31) e = 31;
    mHalf   = 32'd1 << e;
    mStart  = mCyc;
    mActive = 1'b1;
    mTick   = 1'b1;
  endtask

  task automatic modelStep();
    logic [1:0]       sMode, prevAct;
    logic [SEL_W-1:0] sDev;
    logic             sStep, rise, cont;
    sMode = mMode2; sDev = mDev2; sStep = mStep2; rise = mRise;
    mMode2 = mMode1; mMode1 = mode;
    mDev2  = mDev1;  mDev1  = devide;
    mStep2 = mStep1; mStep1 = step;

    mRise = 1'b0;
    if (sStep != mLevel) begin
      mRun++;
      if (mRun == DB_CYCLES) begin
        mLevel = ~mLevel;
        mRun   = 0;
        mRise  = mLevel;
      end
    end else begin
      mRun = 0;
    end

    mCyc++;
    mTick = 1'b0;
    if (!mActive) begin
      if (mAct == M_RUN || ((mAct == M_STEP || mAct == M_BURST) && rise)) begin
        if (mAct == M_STEP) mLeft = 1;
        else if (mAct == M_BURST) mLeft = (burstLen == 0) ? 1 : int'(burstLen);
        else mLeft = 0;
        startPeriod(sDev);
      end
      mAct = sMode;
    end else if (mCyc - mStart == 2 * mHalf) begin
      prevAct = mAct;
      mAct    = sMode;
      if (sMode == M_RUN) cont = 1'b1;
      else if (sMode == M_STOP) cont = 1'b0;
      else if (prevAct == M_RUN) cont = 1'b0;
      else begin
        mLeft--;
        cont = (mLeft > 0);
      end
      if (cont) startPeriod(sDev);
      else mActive = 1'b0;
    end
  endtask

  function automatic logic modelClk();
    return mActive && ((mCyc - mStart) < mHalf);
  endfunction

  task automatic doCycle();
    @(negedge clkIn);
    modelStep();
    checkVal("clkOut", 32'(clkOut), 32'(modelClk()));
    checkVal("tick", 32'(tick), 32'(mTick));
    checkVal("busy", 32'(busy), 32'(mActive));
    if (tick === 1'b1) dutTicks++;
    if (mTick) modelTicks++;
  endtask

  task automatic runCycles(input int n);
    repeat (n) doCycle();
  endtask

  task automatic phaseEnd(input string tag);
    checkVal({tag, "_ticks"}, 32'(dutTicks), 32'(modelTicks));
    $display("phase %0d %s: mode=%0d devide=%0d burstLen=%0d ticks=%0d", phaseNo, tag, mode,
             devide, burstLen, dutTicks);
    phaseNo++;
    dutTicks   = 0;
    modelTicks = 0;
  endtask

  // Called right after a negedge; asserts reset between edges.
  task automatic asyncReset(input int holdCycles);
    #2 rst_n = 1'b0;
    #1;
    checkVal("rst_clkOut", 32'(clkOut), 32'd0);
    checkVal("rst_tick", 32'(tick), 32'd0);
    checkVal("rst_busy", 32'(busy), 32'd0);
    modelReset();
    repeat (holdCycles) begin
      @(negedge clkIn);
      checkVal("rsthold_clkOut", 32'(clkOut), 32'd0);
      checkVal("rsthold_busy", 32'(busy), 32'd0);
      mode = 2'($urandom); devide = SEL_W'($urandom); step = 1'($urandom);
    end
    rst_n = 1'b1;
  endtask

  task automatic pressStep(input int bounce, input int hold);
    int n;
    n = 0;
    while (n < bounce) begin
      step = ~step;
      doCycle();
      n++;
      if ($urandom_range(0, 1) == 1) begin
        doCycle();
        n++;
      end
    end
    step = 1'b1;
    repeat (hold) doCycle();
    step = 1'b0;
    repeat (hold) doCycle();
  endtask

  initial begin
    int nt;
    rst_n = 1'b0; mode = M_RUN; devide = '0; step = 1'b0; burstLen = '0;
    mCyc = 0;
    modelReset();

    repeat (3) begin
      @(negedge clkIn);
      checkVal("reset_clkOut", 32'(clkOut), 32'd0);
      checkVal("reset_tick", 32'(tick), 32'd0);
      checkVal("reset_busy", 32'(busy), 32'd0);
      mode = 2'($urandom); devide = SEL_W'($urandom); step = 1'($urandom);
      burstLen = BL_W'($urandom);
    end
    @(negedge clkIn);
    mode = M_STOP; devide = '0; step = 1'b0; rst_n = 1'b1;
    runCycles(12);
    checkVal("stop_ticks", 32'(dutTicks), 32'd0);
    phaseEnd("stop");

    mode = M_RUN;
    runCycles(40);
    phaseEnd("run_div0");

    for (int i = 0; i < 20; i++) begin
      doCycle();
      if (mTick) break;
    end
    doCycle();
    devide = 2'd2;
    runCycles(60);
    phaseEnd("run_div_change");

    devide = '0;
    mode   = M_STEP;
    runCycles(40);
    phaseEnd("run_to_step");
    pressStep(20, 10);
    runCycles(10);
    checkVal("step_ticks", 32'(dutTicks), 32'd1);
    phaseEnd("step_bounce");

    mode = M_BURST; burstLen = 4'd3;
    runCycles(4);
    pressStep(0, 10);
    runCycles(10);
    checkVal("burst3_ticks", 32'(dutTicks), 32'd3);
    phaseEnd("burst3");

    burstLen = 4'd0;
    pressStep(0, 10);
    runCycles(10);
    checkVal("burst0_ticks", 32'(dutTicks), 32'd1);
    phaseEnd("burst0");

    burstLen = 4'd5;
    step = 1'b1;
    nt = 0;
    for (int i = 0; i < 200 && nt < 2; i++) begin
      doCycle();
      if (mTick) nt++;
    end
    doCycle();
    mode = M_STOP;
    step = 1'b0;
    runCycles(30);
    checkVal("burst5_stop_ticks", 32'(dutTicks), 32'd2);
    phaseEnd("burst5_stop");

    mode = M_RUN; devide = 2'd1;
    runCycles(8);
    for (int i = 0; i < 40; i++) begin
      doCycle();
      if (modelClk()) break;
    end
    asyncReset(2);
    mode = M_STOP; step = 1'b0;
    runCycles(12);
    phaseEnd("reset_mid_high");

    for (int it = 0; it < 40; it++) begin
      int sel;
      sel = $urandom_range(0, 5);
      mode = 2'($urandom); devide = SEL_W'($urandom); burstLen = BL_W'($urandom);
      case (sel)
        0, 1: begin
          repeat ($urandom_range(10, 50)) begin
            if ($urandom_range(0, 7) == 0) devide = SEL_W'($urandom);
            doCycle();
          end
        end
        2, 3: pressStep($urandom_range(0, 12), $urandom_range(2, 12));
        4: begin
          repeat (3) begin
            mode = 2'($urandom);
            runCycles($urandom_range(3, 20));
          end
        end
        default: begin
          doCycle();
          asyncReset($urandom_range(1, 3));
          runCycles(5);
        end
      endcase
      phaseEnd("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sm_clk_ctrl.md
SM_CLK_CTRL -- requirements
Module: sm_clk_ctrl

Interface
REQ-001 SHALL have parameter SHIFT, default 16: base exponent; half-period = 2^(SHIFT+devide) clkIn cycles.
REQ-002 SHALL have parameter SEL_W, default 4: width of devide.
REQ-003 SHALL have parameter BL_W, default 8: width of burstLen.
REQ-004 SHALL have parameter DB_CYCLES, default 16: consecutive stable cycles required to accept a new step level.
REQ-005 SHALL have one clock and an asynchronous, active-low reset: clkIn input 1, rising-edge clock; rst_n input 1, asynchronous active-low reset.
REQ-006 SHALL have port devide, input, SEL_W: division select, asynchronous source.
REQ-007 SHALL have port mode, input, 2: 00 STOP, 01 RUN, 10 STEP, 11 BURST; asynchronous source.
REQ-008 SHALL have port step, input, 1: raw step button, asynchronous and bouncing.
REQ-009 SHALL have port burstLen, input, BL_W: periods per BURST request; quasi-static.
REQ-010 SHALL have port clkOut, output, 1: registered generated clock.
REQ-011 SHALL have port tick, output, 1: one-cycle strobe in the cycle clkOut first reads 1.
REQ-012 SHALL have port busy, output, 1: high whenever the FSM is not IDLE.

Function
REQ-013 SHALL pass devide, mode and step each through a 2-flop synchronizer before use.
REQ-014 SHALL debounce the synchronized step with a counter that increments while syncStep != dbLevel, clears when they match, and flips dbLevel when DB_CYCLES consecutive mismatches have occurred.
REQ-015 SHALL generate stepReq as a one-cycle pulse on each 0->1 transition of dbLevel; a 1->0 transition SHALL produce no pulse.
REQ-016 SHALL implement FSM states IDLE, HIGH and LOW, with a half-period counter halfCnt.
REQ-017 SHALL latch b = min(SHIFT+syncDevide, 31) on every entry to HIGH and hold b constant for the whole period; a devide change SHALL take effect only at the next period.
REQ-018 SHALL latch the active mode (actMode) in IDLE and at the end of every LOW phase only.
REQ-019 IDLE -> HIGH SHALL occur when actMode=RUN, or when actMode is STEP or BURST and stepReq=1; otherwise the FSM SHALL stay in IDLE.
REQ-020 On IDLE -> HIGH, the FSM SHALL load remain = 1 for STEP, or max(burstLen,1) for BURST.
REQ-021 HIGH -> LOW SHALL occur when halfCnt = 2^b-1; LOW -> next state SHALL occur when halfCnt = 2^b-1; halfCnt SHALL clear on every state change.
REQ-022 At the end of LOW: if the newly latched mode is RUN -> HIGH; STOP -> IDLE; STEP/BURST entered from RUN -> IDLE; otherwise decrement remain and go to HIGH if the result is nonzero, else IDLE.
REQ-023 clkOut SHALL be 1 exactly while in HIGH, so every high and low phase is exactly 2^b cycles (no runt pulses, glitch-free).
REQ-024 tick SHALL be asserted for exactly one cycle per HIGH entry, coincident with the first clkOut=1 cycle.
REQ-025 stepReq SHALL be discarded while in HIGH or LOW, or while actMode is RUN or STOP; it SHALL NOT be queued.
REQ-026 A switch to STOP mid-period SHALL complete the current period, then go to IDLE, discarding any remaining burst count.
REQ-027 The first clkOut=1 SHALL occur no earlier than 2+DB_CYCLES and no later than 2+DB_CYCLES+3 clkIn edges after step is stably high in STEP mode.

Reset
REQ-028 While rst_n=0, all registers SHALL clear immediately and asynchronously: FSM=IDLE, clkOut=0, tick=0, busy=0, halfCnt=0, remain=0, dbLevel=0, synchronizers=0, actMode=STOP.
REQ-029 A reset in HIGH or LOW SHALL drop clkOut to 0 immediately; after release no tick SHALL occur without a fresh qualifying request.

Verification (SHIFT=1, SEL_W=2, DB_CYCLES=4, BL_W=4)
REQ-030 Reset held, any inputs -> clkOut=0, tick=0, busy=0; release with mode=STOP -> outputs remain 0.
REQ-031 mode=RUN, devide=0 -> clkOut 2 high/2 low, tick every 4 cycles, busy=1 constantly.
REQ-032 RUN, devide 0->2 applied 1 cycle into HIGH -> current period stays 4 cycles, following periods are 8 high/8 low.
REQ-033 STEP, step toggling every 1-2 cycles for 20 cycles then held high 10 cycles -> exactly one tick, one 2/2 period, then busy=0.
REQ-034 BURST, burstLen=3, one clean press -> three ticks 4 cycles apart, busy falls after the third LOW; burstLen=0 -> exactly one period.
REQ-035 BURST burstLen=5, mode->STOP during the 2nd HIGH -> that period completes, no 3rd tick, busy=0; rst_n low mid-HIGH -> clkOut=0 the same cycle.
